spi_flash_sram_loader: RTL and testbench

- Parametrised bootstrap copy engine: on start, streams a boot image from SPI flash (READ 0x03) and writes it word-by-word into asynchronous SRAM/PSRAM.
- Image format: MAGIC word, LEN word, LEN data words, optional CRC word.
- Generalises the fixed-width bootstrap with configurable address width, base addresses, SPI rate and write-pulse width, plus header validation and explicit done/error reporting.
- Sits between board SPI flash and SRAM, ahead of the processor release.

---
 rtl/spi_flash_sram_loader.sv | 355 +++++++++++++++++++++++++++++++++++
 tb/tb_spi_flash_sram_loader.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_sram_loader.sv
// spi_flash_sram_loader
// Bootstrap copy engine. On start it reads a boot image from SPI flash using
// READ (0x03) in SPI mode 0 and writes it word by word into asynchronous
// SRAM/PSRAM. Image layout: MAGIC, LEN, LEN data words, optional CRC word.
// Optional feature macro: BOOT_CRC_EN. When defined, a CRC-16/CCITT
// (poly 0x1021, init 0xFFFF, MSB first) over the data words is checked
// against a trailing image word.
module spi_flash_sram_loader #(
    parameter int          ADDR_W     = 22,
    parameter logic [23:0] FLASH_BASE = 24'h000000,
    parameter int unsigned SRAM_BASE  = 0,
    parameter int          CLK_DIV    = 4,
    parameter int          WE_CYCLES  = 3,
    parameter logic [15:0] MAGIC      = 16'hB007
) (
    input  logic              master_clk_i,
    input  logic              master_rst_i,
    input  logic              start_i,
    input  logic              MISO,
    output logic              MOSI,
    output logic              SS,
    output logic              SCK_SPI,
    output logic [ADDR_W-1:0] sram_address_o,
    output logic [15:0]       sram_datain_o,
    output logic              sram_cs_o,
    output logic              sram_oe_o,
    output logic              sram_we_o,
    output logic              sram_adv_o,
    output logic              sram_wait_o,
    output logic [1:0]        sram_lb_ub_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              error
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CMD,
        ST_MAGIC,
        ST_LEN,
        ST_DATA,
        ST_WR_SETUP,
        ST_WR_PULSE,
        ST_WR_HOLD,
        ST_CHK,
        ST_FINISH,
        ST_ERR
    } state_t;

    localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
    localparam logic [15:0] WE_LAST   = 16'(WE_CYCLES - 1);
    localparam logic [32:0] SRAM_SPAN = 33'd1 << ADDR_W;

`ifdef BOOT_CRC_EN
    // CHK reads one more word from flash only when the CRC check is built in.
    localparam logic CHK_SHIFTS = 1'b1;

    // CRC-16/CCITT update over one 16-bit word, MSB first.
    function automatic logic [15:0] crc16_word(input logic [15:0] crc_in,
                                               input logic [15:0] data_in);
        logic [15:0] c;
        c = crc_in;
        for (int i = 15; i >= 0; i--) begin
            if ((c[15] ^ data_in[i]) == 1'b1) begin
                c = {c[14:0], 1'b0} ^ 16'h1021;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction
`else
    localparam logic CHK_SHIFTS = 1'b0;
`endif

    state_t            state_q, state_d;
    logic [15:0]       div_q, div_d;
    logic [5:0]        bit_cnt_q, bit_cnt_d;
    logic              sck_q, sck_d;
    logic              ss_q, ss_d;
    logic [31:0]       tx_q, tx_d;
    logic [15:0]       rx_q, rx_d;
    logic [15:0]       remaining_q, remaining_d;
    logic [15:0]       wcnt_q, wcnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       data_q, data_d;
    logic              cs_q, cs_d;
    logic              we_q, we_d;
    logic              adv_q, adv_d;
    logic [1:0]        lb_ub_q, lb_ub_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
`ifdef BOOT_CRC_EN
    logic [15:0]       crc_q, crc_d;
`endif

    logic              shifting_s;
    logic              phase_done_s;
    logic [5:0]        bits_needed_s;
    logic [32:0]       len_end_s;

    assign MOSI           = tx_q[31];
    assign SS             = ss_q;
    assign SCK_SPI        = sck_q;
    assign sram_address_o = addr_q;
    assign sram_datain_o  = data_q;
    assign sram_cs_o      = cs_q;
    assign sram_oe_o      = 1'b1;
    assign sram_we_o      = we_q;
    assign sram_adv_o     = adv_q;
    assign sram_wait_o    = 1'b0;
    assign sram_lb_ub_o   = lb_ub_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign error          = err_q;

    // State, SPI shifter, SRAM strobe and status registers with synchronous reset.
    always_ff @(posedge master_clk_i) begin
        if (master_rst_i) begin
            state_q     <= ST_IDLE;
            div_q       <= 16'd0;
            bit_cnt_q   <= 6'd0;
            sck_q       <= 1'b0;
            ss_q        <= 1'b1;
            tx_q        <= 32'd0;
            rx_q        <= 16'd0;
            remaining_q <= 16'd0;
            wcnt_q      <= 16'd0;
            addr_q      <= '0;
            data_q      <= 16'd0;
            cs_q        <= 1'b1;
            we_q        <= 1'b1;
            adv_q       <= 1'b1;
            lb_ub_q     <= 2'b11;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef BOOT_CRC_EN
            crc_q       <= 16'hFFFF;
`endif
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_cnt_q   <= bit_cnt_d;
            sck_q       <= sck_d;
            ss_q        <= ss_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            remaining_q <= remaining_d;
            wcnt_q      <= wcnt_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            cs_q        <= cs_d;
            we_q        <= we_d;
            adv_q       <= adv_d;
            lb_ub_q     <= lb_ub_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
`ifdef BOOT_CRC_EN
            crc_q       <= crc_d;
`endif
        end
    end

    // Next state, SPI bit engine, SRAM write sequencing and status flags.
    always_comb begin
        state_d       = state_q;
        div_d         = div_q;
        bit_cnt_d     = bit_cnt_q;
        sck_d         = sck_q;
        ss_d          = ss_q;
        tx_d          = tx_q;
        rx_d          = rx_q;
        remaining_d   = remaining_q;
        wcnt_d        = wcnt_q;
        addr_d        = addr_q;
        data_d        = data_q;
        cs_d          = cs_q;
        we_d          = we_q;
        adv_d         = adv_q;
        lb_ub_d       = lb_ub_q;
        busy_d        = busy_q;
        done_d        = done_q;
        err_d         = err_q;
`ifdef BOOT_CRC_EN
        crc_d         = crc_q;
`endif
        phase_done_s  = 1'b0;
        len_end_s     = 33'(SRAM_BASE) + {17'd0, rx_q};
        bits_needed_s = (state_q == ST_CMD) ? 6'd32 : 6'd16;
        shifting_s    = (state_q == ST_CMD) || (state_q == ST_MAGIC) ||
                        (state_q == ST_LEN) || (state_q == ST_DATA) ||
                        ((state_q == ST_CHK) && CHK_SHIFTS);

        // SCK toggles every CLK_DIV clocks: MISO is captured on the clock that
        // raises SCK, MOSI advances on the clock that lowers it. A field is
        // complete on the falling edge after its last rising edge, so SCK is
        // always low when the FSM leaves a shifting state.
        if (shifting_s) begin
            if (div_q == DIV_LAST) begin
                div_d = 16'd0;
                if (!sck_q) begin
                    sck_d     = 1'b1;
                    rx_d      = {rx_q[14:0], MISO};
                    bit_cnt_d = bit_cnt_q + 6'd1;
                end else begin
                    sck_d = 1'b0;
                    tx_d  = {tx_q[30:0], 1'b0};
                    if (bit_cnt_q == bits_needed_s) begin
                        phase_done_s = 1'b1;
                        bit_cnt_d    = 6'd0;
                    end else begin
                        phase_done_s = 1'b0;
                    end
                end
            end else begin
                div_d = div_q + 16'd1;
            end
        end else begin
            div_d = 16'd0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d   = ST_CMD;
                    tx_d      = {8'h03, FLASH_BASE};
                    bit_cnt_d = 6'd0;
                    sck_d     = 1'b0;
                    done_d    = 1'b0;
                    err_d     = 1'b0;
`ifdef BOOT_CRC_EN
                    crc_d     = 16'hFFFF;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CMD: begin
                if (phase_done_s) begin
                    state_d = ST_MAGIC;
                end else begin
                    state_d = ST_CMD;
                end
            end
            ST_MAGIC: begin
                if (phase_done_s) begin
                    state_d = (rx_q == MAGIC) ? ST_LEN : ST_ERR;
                end else begin
                    state_d = ST_MAGIC;
                end
            end
            ST_LEN: begin
                if (phase_done_s) begin
                    if (len_end_s > SRAM_SPAN) begin
                        state_d = ST_ERR;
                    end else if (rx_q == 16'd0) begin
                        state_d = ST_CHK;
                    end else begin
                        state_d     = ST_DATA;
                        remaining_d = rx_q;
                        addr_d      = ADDR_W'(SRAM_BASE);
                    end
                end else begin
                    state_d = ST_LEN;
                end
            end
            ST_DATA: begin
                if (phase_done_s) begin
                    state_d = ST_WR_SETUP;
                    data_d  = rx_q;
`ifdef BOOT_CRC_EN
                    crc_d   = crc16_word(crc_q, rx_q);
`endif
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_WR_SETUP: begin
                state_d = ST_WR_PULSE;
                wcnt_d  = 16'd0;
            end
            ST_WR_PULSE: begin
                if (wcnt_q == WE_LAST) begin
                    state_d = ST_WR_HOLD;
                end else begin
                    wcnt_d = wcnt_q + 16'd1;
                end
            end
            ST_WR_HOLD: begin
                remaining_d = remaining_q - 16'd1;
                if (remaining_q == 16'd1) begin
                    state_d = ST_CHK;
                end else begin
                    state_d = ST_DATA;
                    addr_d  = addr_q + ADDR_W'(1);
                end
            end
            ST_CHK: begin
`ifdef BOOT_CRC_EN
                if (phase_done_s) begin
                    state_d = (rx_q == crc_q) ? ST_FINISH : ST_ERR;
                end else begin
                    state_d = ST_CHK;
                end
`else
                state_d = ST_FINISH;
`endif
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Flash select, SCK parking and busy follow the state being entered.
        if ((state_d == ST_IDLE) || (state_d == ST_FINISH) || (state_d == ST_ERR)) begin
            ss_d   = 1'b1;
            sck_d  = 1'b0;
            busy_d = 1'b0;
        end else begin
            ss_d   = 1'b0;
            busy_d = 1'b1;
        end

        // SRAM strobes are active only across setup, pulse and hold.
        if ((state_d == ST_WR_SETUP) || (state_d == ST_WR_PULSE) || (state_d == ST_WR_HOLD)) begin
            cs_d    = 1'b0;
            adv_d   = 1'b0;
            lb_ub_d = 2'b00;
        end else begin
            cs_d    = 1'b1;
            adv_d   = 1'b1;
            lb_ub_d = 2'b11;
        end
        we_d = (state_d == ST_WR_PULSE) ? 1'b0 : 1'b1;

        // Sticky completion flags; both are cleared when a new load starts.
        if (state_d == ST_FINISH) begin
            done_d = 1'b1;
        end else if (state_d == ST_ERR) begin
            err_d = 1'b1;
        end else begin
            done_d = done_d;
        end
    end

endmodule

// File: tb/tb_spi_flash_sram_loader.sv
// Self-checking bench for spi_flash_sram_loader: behavioural SPI flash model,
// SRAM write monitor with an expected-write scoreboard, and scenario tasks.
`timescale 1ns/1ps
module tb_spi_flash_sram_loader;

    localparam int          ADDR_W     = 10;
    localparam logic [23:0] FLASH_BASE = 24'h012340;
    localparam int unsigned SRAM_BASE  = 1020;
    localparam int          CLK_DIV    = 2;
    localparam int          WE_CYCLES  = 3;
    localparam logic [15:0] MAGIC      = 16'hB007;
`ifdef BOOT_CRC_EN
    localparam int CRC_WORDS = 1;
`else
    localparam int CRC_WORDS = 0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              miso = 1'b0;
    logic              MOSI, SS, SCK_SPI;
    logic [ADDR_W-1:0] sram_address_o;
    logic [15:0]       sram_datain_o;
    logic              sram_cs_o, sram_oe_o, sram_we_o, sram_adv_o, sram_wait_o;
    logic [1:0]        sram_lb_ub_o;
    logic              busy_o, done_o, error;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
    } wr_t;

    wr_t               exp_q[$];
    int                checks = 0;
    int                errors = 0;
    logic [15:0]       img [0:31];
    int                img_len = 0;
    int                rise_cnt = 0;
    int                ss_falls = 0;
    logic [31:0]       cmd_shift = 32'd0;
    int                fk;
    int                we_w = 0;
    int                wr_count = 0;
    bit                drop_write = 1'b0;
    logic [ADDR_W-1:0] w_addr;
    logic [15:0]       w_data;
    wr_t               e;

    spi_flash_sram_loader #(
        .ADDR_W(ADDR_W), .FLASH_BASE(FLASH_BASE), .SRAM_BASE(SRAM_BASE),
        .CLK_DIV(CLK_DIV), .WE_CYCLES(WE_CYCLES), .MAGIC(MAGIC)
    ) dut (
        .master_clk_i(clk), .master_rst_i(rst), .start_i(start),
        .MISO(miso), .MOSI(MOSI), .SS(SS), .SCK_SPI(SCK_SPI),
        .sram_address_o(sram_address_o), .sram_datain_o(sram_datain_o),
        .sram_cs_o(sram_cs_o), .sram_oe_o(sram_oe_o), .sram_we_o(sram_we_o),
        .sram_adv_o(sram_adv_o), .sram_wait_o(sram_wait_o),
        .sram_lb_ub_o(sram_lb_ub_o), .busy_o(busy_o), .done_o(done_o), .error(error)
    );

    always #5 clk = ~clk;

    // Flash model: capture command bits on SCK rise, serve image on SCK fall.
    always @(posedge SCK_SPI) begin
        if (rise_cnt < 32) cmd_shift = {cmd_shift[30:0], MOSI};
        rise_cnt = rise_cnt + 1;
    end

    always @(negedge SCK_SPI) begin
        fk = rise_cnt - 32;
        if (fk >= 0 && (fk / 16) < img_len) miso = img[fk / 16][15 - (fk % 16)];
        else miso = 1'b0;
    end

    always @(negedge SS) ss_falls = ss_falls + 1;

    // SRAM monitor: on each completed write, pop and compare the scoreboard.
    always @(negedge clk) begin
        if (!sram_we_o) begin
            if (we_w == 0) begin
                w_addr = sram_address_o;
                w_data = sram_datain_o;
            end
            we_w = we_w + 1;
        end else if (we_w != 0) begin
            if (!drop_write) begin
                wr_count = wr_count + 1;
                checks = checks + 1;
                if (exp_q.size() == 0) begin
                    errors = errors + 1;
                    $display("FAIL unexpected_write addr=%0d data=%h", w_addr, w_data);
                end else begin
                    e = exp_q.pop_front();
                    if (w_addr !== e.addr || sram_address_o !== e.addr) begin
                        errors = errors + 1;
                        $display("FAIL write_addr got=%0d/%0d exp=%0d", w_addr, sram_address_o, e.addr);
                    end
                    checks = checks + 1;
                    if (w_data !== e.data || sram_datain_o !== e.data) begin
                        errors = errors + 1;
                        $display("FAIL write_data got=%h/%h exp=%h", w_data, sram_datain_o, e.data);
                    end
                    checks = checks + 1;
                    if (we_w != WE_CYCLES) begin
                        errors = errors + 1;
                        $display("FAIL we_width got=%0d exp=%0d", we_w, WE_CYCLES);
                    end
                    checks = checks + 1;
                    if (sram_cs_o !== 1'b0 || sram_adv_o !== 1'b0 || sram_lb_ub_o !== 2'b00) begin
                        errors = errors + 1;
                        $display("FAIL hold_strobes got cs=%b adv=%b lbub=%b exp 0/0/00",
                                 sram_cs_o, sram_adv_o, sram_lb_ub_o);
                    end
                end
            end
            we_w = 0;
        end
    end

    // Stimulus helpers.
    task automatic finish_image(input int ndata);
`ifdef BOOT_CRC_EN
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int w = 0; w < ndata; w++) begin
            for (int b = 15; b >= 0; b--) begin
                fb = c[15] ^ img[2 + w][b];
                c  = {c[14:0], 1'b0};
                if (fb) c = c ^ 16'h1021;
            end
        end
        img[2 + ndata] = c;
        img_len = ndata + 3;
`else
        img_len = ndata + 2;
`endif
    endtask

    task automatic push_writes(input int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back({ADDR_W'(SRAM_BASE + i), img[2 + i]});
    endtask

    task automatic start_load();
        rise_cnt = 0; cmd_shift = 32'd0; ss_falls = 0; wr_count = 0; miso = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_idle(output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 20000; i++) begin
            if (!busy_o) begin timed_out = 1'b0; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if ({SS, SCK_SPI, MOSI} !== 3'b100) begin errors++;
            $display("FAIL reset_flash got SS/SCK/MOSI=%b exp=100", {SS, SCK_SPI, MOSI}); end
        checks++; if ({sram_cs_o, sram_we_o, sram_oe_o, sram_adv_o, sram_lb_ub_o, sram_wait_o} !== 7'b1111110) begin errors++;
            $display("FAIL reset_sram_strobes got=%b exp=1111110",
                     {sram_cs_o, sram_we_o, sram_oe_o, sram_adv_o, sram_lb_ub_o, sram_wait_o}); end
        checks++; if (sram_address_o !== '0 || sram_datain_o !== 16'd0) begin errors++;
            $display("FAIL reset_sram_bus got addr=%0d data=%h exp 0/0", sram_address_o, sram_datain_o); end
        checks++; if ({busy_o, done_o, error} !== 3'b000) begin errors++;
            $display("FAIL reset_status got=%b exp=000", {busy_o, done_o, error}); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_load();
        bit to;
        img[0] = MAGIC; img[1] = 16'd3; img[2] = 16'h1234; img[3] = 16'hABCD; img[4] = 16'h0F0F;
        finish_image(3);
        push_writes(3);
        start_load();
        wait_idle(to);
        checks++; if (to) begin errors++; $display("FAIL basic_timeout got busy=%b exp=0", busy_o); end
        checks++; if ({done_o, error, SS} !== 3'b101) begin errors++;
            $display("FAIL basic_status got done/err/SS=%b exp=101", {done_o, error, SS}); end
        checks++; if (wr_count != 3 || exp_q.size() != 0) begin errors++;
            $display("FAIL basic_writes got=%0d left=%0d exp=3/0", wr_count, exp_q.size()); end
        checks++; if (cmd_shift !== {8'h03, FLASH_BASE}) begin errors++;
            $display("FAIL basic_cmd got=%h exp=%h", cmd_shift, {8'h03, FLASH_BASE}); end
        checks++; if (rise_cnt != 32 + 16 * (5 + CRC_WORDS)) begin errors++;
            $display("FAIL basic_sck_rises got=%0d exp=%0d", rise_cnt, 32 + 16 * (5 + CRC_WORDS)); end
        exp_q.delete();
    endtask

    task automatic test_bad_magic();
        bit to;
        img[0] = 16'hB008; img[1] = 16'd3; img[2] = 16'h1111; img[3] = 16'h2222; img[4] = 16'h3333;
        finish_image(3);
        start_load();
        wait_idle(to);
        checks++; if (to) begin errors++; $display("FAIL magic_timeout got busy=%b exp=0", busy_o); end
        checks++; if ({done_o, error, SS, busy_o} !== 4'b0110) begin errors++;
            $display("FAIL magic_status got done/err/SS/busy=%b exp=0110", {done_o, error, SS, busy_o}); end
        checks++; if (wr_count != 0 || we_w != 0) begin errors++;
            $display("FAIL magic_writes got=%0d exp=0", wr_count); end
        checks++; if (rise_cnt != 48) begin errors++;
            $display("FAIL magic_sck_rises got=%0d exp=48", rise_cnt); end
    endtask

    task automatic test_len_limits();
        bit to;
        img[0] = MAGIC; img[1] = 16'd5;
        for (int i = 0; i < 5; i++) img[2 + i] = 16'hC000 + 16'(i);
        finish_image(5);
        start_load();
        wait_idle(to);
        checks++; if (to || {done_o, error} !== 2'b01) begin errors++;
            $display("FAIL len_over_status got to=%b done/err=%b exp 0/01", to, {done_o, error}); end
        checks++; if (wr_count != 0 || rise_cnt != 64) begin errors++;
            $display("FAIL len_over_activity got writes=%0d rises=%0d exp 0/64", wr_count, rise_cnt); end
        img[1] = 16'd4;
        finish_image(4);
        push_writes(4);
        start_load();
        wait_idle(to);
        checks++; if (to || {done_o, error} !== 2'b10) begin errors++;
            $display("FAIL len_edge_status got to=%b done/err=%b exp 0/10", to, {done_o, error}); end
        checks++; if (wr_count != 4 || exp_q.size() != 0) begin errors++;
            $display("FAIL len_edge_writes got=%0d left=%0d exp=4/0", wr_count, exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_len_zero();
        bit to;
        img[0] = MAGIC; img[1] = 16'd0;
        finish_image(0);
        start_load();
        wait_idle(to);
        checks++; if (to || {done_o, error} !== 2'b10) begin errors++;
            $display("FAIL len0_status got to=%b done/err=%b exp 0/10", to, {done_o, error}); end
        checks++; if (wr_count != 0) begin errors++; $display("FAIL len0_writes got=%0d exp=0", wr_count); end
        checks++; if (rise_cnt != 64 + 16 * CRC_WORDS) begin errors++;
            $display("FAIL len0_sck_rises got=%0d exp=%0d", rise_cnt, 64 + 16 * CRC_WORDS); end
    endtask

    task automatic test_reset_mid_write();
        bit found;
        img[0] = MAGIC; img[1] = 16'd2; img[2] = 16'h5A5A; img[3] = 16'hA5A5;
        finish_image(2);
        start_load();
        found = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (!sram_we_o) begin found = 1'b1; break; end
        end
        checks++; if (!found) begin errors++; $display("FAIL rstwr_no_we got we=%b exp=0", sram_we_o); end
        drop_write = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        checks++; if ({sram_we_o, sram_cs_o, SS, busy_o} !== 4'b1110) begin errors++;
            $display("FAIL rstwr_state got we/cs/SS/busy=%b exp=1110", {sram_we_o, sram_cs_o, SS, busy_o}); end
        checks++; if ({SCK_SPI, sram_adv_o, done_o, error} !== 4'b0100) begin errors++;
            $display("FAIL rstwr_misc got sck/adv/done/err=%b exp=0100", {SCK_SPI, sram_adv_o, done_o, error}); end
        rst = 1'b0;
        @(negedge clk);
        drop_write = 1'b0;
    endtask

    task automatic test_start_while_busy();
        bit to;
        img[0] = MAGIC; img[1] = 16'd3; img[2] = 16'h0001; img[3] = 16'h8000; img[4] = 16'hFFFF;
        finish_image(3);
        push_writes(3);
        start_load();
        repeat (20) @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;
        repeat (150) @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;
        wait_idle(to);
        checks++; if (to || {done_o, error} !== 2'b10) begin errors++;
            $display("FAIL busy_start_status got to=%b done/err=%b exp 0/10", to, {done_o, error}); end
        checks++; if (ss_falls != 1 || cmd_shift !== {8'h03, FLASH_BASE}) begin errors++;
            $display("FAIL busy_start_cmd got ss_falls=%0d cmd=%h exp 1/%h", ss_falls, cmd_shift, {8'h03, FLASH_BASE}); end
        checks++; if (rise_cnt != 32 + 16 * (5 + CRC_WORDS) || wr_count != 3) begin errors++;
            $display("FAIL busy_start_count got rises=%0d writes=%0d exp %0d/3", rise_cnt, wr_count, 32 + 16 * (5 + CRC_WORDS)); end
        exp_q.delete();
    endtask

`ifdef BOOT_CRC_EN
    task automatic test_crc();
        bit to;
        img[0] = MAGIC; img[1] = 16'd3; img[2] = 16'hDEAD; img[3] = 16'hBEEF; img[4] = 16'h0042;
        finish_image(3);
        push_writes(3);
        start_load();
        wait_idle(to);
        checks++; if (to || {done_o, error} !== 2'b10) begin errors++;
            $display("FAIL crc_good got to=%b done/err=%b exp 0/10", to, {done_o, error}); end
        img[5] = img[5] ^ 16'h0001;
        push_writes(3);
        start_load();
        wait_idle(to);
        checks++; if (to || {done_o, error} !== 2'b01) begin errors++;
            $display("FAIL crc_bad got to=%b done/err=%b exp 0/01", to, {done_o, error}); end
        checks++; if (wr_count != 3 || exp_q.size() != 0) begin errors++;
            $display("FAIL crc_bad_writes got=%0d left=%0d exp=3/0", wr_count, exp_q.size()); end
        exp_q.delete();
    endtask
`endif

    initial begin
        test_reset();
        test_basic_load();
        test_bad_magic();
        test_len_limits();
        test_len_zero();
        test_reset_mid_write();
        test_basic_load();
        test_start_while_busy();
`ifdef BOOT_CRC_EN
        test_crc();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
